// File: rtl/ldst_port_arb_pkg.sv
// Shared definitions for the load/store data-cache port arbiter:
// the arbiter state enum, the one-entry issue register layout and the
// branch-mask width.
`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif

package ldst_port_arb_pkg;

    localparam int BR_MASK_W = `BR_MASK_W;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_ISSUE    = 2'd1,
        ARB_STC_WAIT = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                 is_st;
        logic [63:0]          addr;
        logic [63:0]          data;
        logic                 stc;
        logic [BR_MASK_W-1:0] br_mask;
    } issue_entry_t;

    // True when a load's branch mask depends on any of the given branch tags.
    function automatic logic br_hit(input logic [BR_MASK_W-1:0] mask,
                                    input logic [BR_MASK_W-1:0] tag);
        return |(mask & tag);
    endfunction

endpackage

// File: rtl/ldst_arb_age_ctr.sv
// Store starvation counter: counts cycles a pending store loses
// arbitration, saturating at MAX; sat_o lets the store beat a load.
import ldst_port_arb_pkg::*;

module ldst_arb_age_ctr #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic st_req_i,
    input  logic st_gnt_i,
    output logic sat_o
);

    localparam int W = $clog2(MAX) + 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign sat_o = (cnt_q == W'(MAX));

    // Next count: clear on grant, count up while waiting, hold at saturation.
    always_comb begin
        cnt_d = cnt_q;
        if (st_gnt_i) begin
            cnt_d = '0;
        end else if (st_req_i && !sat_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ldst_port_arb.sv
// Load/store data-cache port arbiter and issue sequencer.
// Grants one of load / retiring store per cycle into a one-entry issue
// register held across MSHR stalls, serialises store-conditional
// completion, and squashes a held load on branch mispredict.
// Optional feature: MEM_ARB_AGE_EN adds the store starvation counter.
//
//   state        | meaning
//   ARB_IDLE     | issue register empty
//   ARB_ISSUE    | request presented to the cache
//   ARB_STC_WAIT | accepted store-conditional awaiting its outcome
import ldst_port_arb_pkg::*;

module ldst_port_arb #(
    parameter int ST_WAIT_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_req_i,
    input  logic [63:0]          ld_addr_i,
    input  logic [BR_MASK_W-1:0] ld_br_mask_i,
    output logic                 ld_gnt_o,
    input  logic                 st_req_i,
    input  logic [63:0]          st_addr_i,
    input  logic [63:0]          st_data_i,
    input  logic                 st_stc_i,
    output logic                 st_gnt_o,
    input  logic                 sq_full_i,
    input  logic                 rob_br_recovery_i,
    input  logic                 rob_br_pred_correct_i,
    input  logic [BR_MASK_W-1:0] rob_br_tag_fix_i,
    input  logic                 Dcache_mshr_stall_i,
    input  logic                 Dcache_stc_success_i,
    input  logic                 Dcache_stc_fail_i,
    output logic                 dc_ld_en_o,
    output logic                 dc_st_en_o,
    output logic [63:0]          dc_ld_addr_o,
    output logic [63:0]          dc_st_addr_o,
    output logic [63:0]          dc_st_data_o,
    output logic                 dc_stc_flag_o,
    output logic                 stc_done_o,
    output logic                 stc_result_o
);

    arb_state_e           state_q, state_d;
    issue_entry_t         entry_q, entry_d, new_entry;
    logic                 stc_done_q, stc_done_d;
    logic                 stc_result_q, stc_result_d;
    logic                 grant_ok;
    logic                 age_sat;
    logic                 st_win;
    logic                 ld_gnt, st_gnt;
    logic                 squash;
    logic [BR_MASK_W-1:0] fix_mask;

`ifdef MEM_ARB_AGE_EN
    ldst_arb_age_ctr #(
        .MAX (ST_WAIT_MAX)
    ) u_age_ctr (
        .clk      (clk),
        .rst      (rst),
        .st_req_i (st_req_i),
        .st_gnt_i (st_gnt),
        .sat_o    (age_sat)
    );
`else
    logic [31:0] unused_cfg;
    assign unused_cfg = 32'(ST_WAIT_MAX);
    assign age_sat    = 1'b0;
`endif

    assign fix_mask = rob_br_pred_correct_i ? rob_br_tag_fix_i : '0;

    assign squash = (state_q == ARB_ISSUE) && !entry_q.is_st && rob_br_recovery_i &&
                    br_hit(entry_q.br_mask, rob_br_tag_fix_i);

    // Grant decision: a load blocked by recovery hands the slot to the store.
    always_comb begin
        grant_ok = (state_q == ARB_IDLE) ||
                   ((state_q == ARB_ISSUE) && !Dcache_mshr_stall_i && !entry_q.stc);
        st_win   = st_req_i && (sq_full_i || !ld_req_i || rob_br_recovery_i || age_sat);
        st_gnt   = grant_ok && st_win;
        ld_gnt   = grant_ok && ld_req_i && !rob_br_recovery_i && !st_win;
    end

    assign ld_gnt_o = ld_gnt;
    assign st_gnt_o = st_gnt;

    // Payload captured into the issue register for whichever side is granted.
    always_comb begin
        new_entry = '0;
        if (st_gnt) begin
            new_entry.is_st = 1'b1;
            new_entry.addr  = st_addr_i;
            new_entry.data  = st_data_i;
            new_entry.stc   = st_stc_i;
        end else begin
            new_entry.addr    = ld_addr_i;
            new_entry.br_mask = ld_br_mask_i & ~fix_mask;
        end
    end

    // Next-state and issue-register update.
    always_comb begin
        state_d         = state_q;
        entry_d         = entry_q;
        entry_d.br_mask = entry_q.br_mask & ~fix_mask;
        stc_done_d      = 1'b0;
        stc_result_d    = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (ld_gnt || st_gnt) begin
                    state_d = ARB_ISSUE;
                    entry_d = new_entry;
                end
            end
            ARB_ISSUE: begin
                if (squash) begin
                    if (st_gnt) begin
                        entry_d = new_entry;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (Dcache_mshr_stall_i) begin
                    state_d = ARB_ISSUE;
                end else if (entry_q.stc) begin
                    state_d = ARB_STC_WAIT;
                end else if (ld_gnt || st_gnt) begin
                    entry_d = new_entry;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_STC_WAIT: begin
                if (Dcache_stc_success_i || Dcache_stc_fail_i) begin
                    state_d      = ARB_IDLE;
                    stc_done_d   = 1'b1;
                    stc_result_d = Dcache_stc_success_i && !Dcache_stc_fail_i;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State, issue register and STC completion registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            entry_q      <= '0;
            stc_done_q   <= 1'b0;
            stc_result_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            entry_q      <= entry_d;
            stc_done_q   <= stc_done_d;
            stc_result_q <= stc_result_d;
        end
    end

    // Cache-facing request decode; payloads are zeroed when not presented.
    always_comb begin
        dc_ld_en_o    = (state_q == ARB_ISSUE) && !entry_q.is_st;
        dc_st_en_o    = (state_q == ARB_ISSUE) && entry_q.is_st;
        dc_ld_addr_o  = dc_ld_en_o ? entry_q.addr : '0;
        dc_st_addr_o  = dc_st_en_o ? entry_q.addr : '0;
        dc_st_data_o  = dc_st_en_o ? entry_q.data : '0;
        dc_stc_flag_o = dc_st_en_o && entry_q.stc;
    end

    assign stc_done_o   = stc_done_q;
    assign stc_result_o = stc_result_q;

endmodule

// File: tb/tb_ldst_port_arb.sv
// Directed bench for ldst_port_arb with hand-computed expectations.
import ldst_port_arb_pkg::*;

module tb_ldst_port_arb;

`ifdef MEM_ARB_AGE_EN
    localparam bit AGE_EN = 1'b1;
`else
    localparam bit AGE_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ld_req_i;
    logic [63:0]          ld_addr_i;
    logic [BR_MASK_W-1:0] ld_br_mask_i;
    logic                 ld_gnt_o;
    logic                 st_req_i;
    logic [63:0]          st_addr_i;
    logic [63:0]          st_data_i;
    logic                 st_stc_i;
    logic                 st_gnt_o;
    logic                 sq_full_i;
    logic                 rob_br_recovery_i;
    logic                 rob_br_pred_correct_i;
    logic [BR_MASK_W-1:0] rob_br_tag_fix_i;
    logic                 Dcache_mshr_stall_i;
    logic                 Dcache_stc_success_i;
    logic                 Dcache_stc_fail_i;
    logic                 dc_ld_en_o;
    logic                 dc_st_en_o;
    logic [63:0]          dc_ld_addr_o;
    logic [63:0]          dc_st_addr_o;
    logic [63:0]          dc_st_data_o;
    logic                 dc_stc_flag_o;
    logic                 stc_done_o;
    logic                 stc_result_o;

    int n_vec = 0;
    int n_err = 0;

    ldst_port_arb #(.ST_WAIT_MAX(4)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .ld_req_i              (ld_req_i),
        .ld_addr_i             (ld_addr_i),
        .ld_br_mask_i          (ld_br_mask_i),
        .ld_gnt_o              (ld_gnt_o),
        .st_req_i              (st_req_i),
        .st_addr_i             (st_addr_i),
        .st_data_i             (st_data_i),
        .st_stc_i              (st_stc_i),
        .st_gnt_o              (st_gnt_o),
        .sq_full_i             (sq_full_i),
        .rob_br_recovery_i     (rob_br_recovery_i),
        .rob_br_pred_correct_i (rob_br_pred_correct_i),
        .rob_br_tag_fix_i      (rob_br_tag_fix_i),
        .Dcache_mshr_stall_i   (Dcache_mshr_stall_i),
        .Dcache_stc_success_i  (Dcache_stc_success_i),
        .Dcache_stc_fail_i     (Dcache_stc_fail_i),
        .dc_ld_en_o            (dc_ld_en_o),
        .dc_st_en_o            (dc_st_en_o),
        .dc_ld_addr_o          (dc_ld_addr_o),
        .dc_st_addr_o          (dc_st_addr_o),
        .dc_st_data_o          (dc_st_data_o),
        .dc_stc_flag_o         (dc_stc_flag_o),
        .stc_done_o            (stc_done_o),
        .stc_result_o          (stc_result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic ld, input logic st);
        chk({tag, ".ld_gnt"}, 64'(ld_gnt_o), 64'(ld));
        chk({tag, ".st_gnt"}, 64'(st_gnt_o), 64'(st));
    endtask

    initial begin
        rst = 1'b1;
        ld_req_i = 0; ld_addr_i = '0; ld_br_mask_i = '0;
        st_req_i = 0; st_addr_i = '0; st_data_i = '0; st_stc_i = 0;
        sq_full_i = 0; rob_br_recovery_i = 0; rob_br_pred_correct_i = 0;
        rob_br_tag_fix_i = '0; Dcache_mshr_stall_i = 0;
        Dcache_stc_success_i = 0; Dcache_stc_fail_i = 0;
        tick(); tick();

        // Reset state
        chk("rst.ld_en", 64'(dc_ld_en_o), 0);
        chk("rst.st_en", 64'(dc_st_en_o), 0);
        chk("rst.done", 64'(stc_done_o), 0);
        chk("rst.result", 64'(stc_result_o), 0);
        chk("rst.ld_addr", dc_ld_addr_o, 0);
        rst = 1'b0;

        // Load 0x100 and store 0x200 from IDLE: load first, store next cycle
        ld_req_i = 1; ld_addr_i = 64'h100;
        st_req_i = 1; st_addr_i = 64'h200; st_data_i = 64'hABCD;
        settle(); chk_gnt("a0", 1, 0);
        tick();
        ld_req_i = 0;
        settle(); chk_gnt("a1", 0, 1);
        chk("a1.ld_en", 64'(dc_ld_en_o), 1);
        chk("a1.ld_addr", dc_ld_addr_o, 64'h100);
        chk("a1.st_en", 64'(dc_st_en_o), 0);
        tick();
        st_req_i = 0;
        chk("a2.st_en", 64'(dc_st_en_o), 1);
        chk("a2.ld_en", 64'(dc_ld_en_o), 0);
        chk("a2.st_addr", dc_st_addr_o, 64'h200);
        chk("a2.st_data", dc_st_data_o, 64'hABCD);
        chk("a2.stc", 64'(dc_stc_flag_o), 0);
        tick();
        chk("a3.st_en", 64'(dc_st_en_o), 0);

        // Load held across 3 stall cycles, no grants while stalled
        ld_req_i = 1; ld_addr_i = 64'h300;
        settle(); chk_gnt("b0", 1, 0);
        tick();
        ld_req_i = 0; st_req_i = 1; st_addr_i = 64'h208; Dcache_mshr_stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("b.stall.ld_en", 64'(dc_ld_en_o), 1);
            chk("b.stall.addr", dc_ld_addr_o, 64'h300);
            chk_gnt("b.stall", 0, 0);
            tick();
        end
        Dcache_mshr_stall_i = 0;
        settle();
        chk("b4.ld_en", 64'(dc_ld_en_o), 1);
        chk("b4.addr", dc_ld_addr_o, 64'h300);
        chk_gnt("b4", 0, 1);
        tick();
        st_req_i = 0;
        chk("b5.st_en", 64'(dc_st_en_o), 1);
        chk("b5.ld_en", 64'(dc_ld_en_o), 0);
        tick();

        // Squash of a stalled load on mispredict
        ld_req_i = 1; ld_addr_i = 64'h400; ld_br_mask_i = 4'b0010;
        settle(); chk_gnt("c0", 1, 0);
        tick();
        ld_req_i = 0; Dcache_mshr_stall_i = 1;
        rob_br_recovery_i = 1; rob_br_tag_fix_i = 4'b0010;
        settle(); chk_gnt("c1", 0, 0);
        chk("c1.ld_en", 64'(dc_ld_en_o), 1);
        tick();
        rob_br_recovery_i = 0; rob_br_tag_fix_i = '0;
        ld_req_i = 1; ld_addr_i = 64'h500; ld_br_mask_i = 4'b0011;
        settle();
        chk("c2.ld_en", 64'(dc_ld_en_o), 0);
        chk_gnt("c2.idle", 1, 0);
        tick();
        ld_req_i = 0;
        // Resolved-correct branch removes the dependency before recovery on it
        rob_br_pred_correct_i = 1; rob_br_tag_fix_i = 4'b0001;
        tick();
        rob_br_pred_correct_i = 0; rob_br_recovery_i = 1;
        settle(); chk("c3.ld_en", 64'(dc_ld_en_o), 1);
        tick();
        rob_br_recovery_i = 0; rob_br_tag_fix_i = '0;
        chk("c4.ld_en", 64'(dc_ld_en_o), 1);
        chk("c4.addr", dc_ld_addr_o, 64'h500);
        Dcache_mshr_stall_i = 0;
        tick();
        chk("c5.ld_en", 64'(dc_ld_en_o), 0);

        // Recovery blocks the load, store still granted
        ld_req_i = 1; st_req_i = 1; rob_br_recovery_i = 1;
        settle(); chk_gnt("r0", 0, 1);
        tick();
        ld_req_i = 0; st_req_i = 0; rob_br_recovery_i = 0;
        tick();

        // STC with simultaneous success and fail reports failure
        st_req_i = 1; st_stc_i = 1; st_addr_i = 64'h600;
        settle(); chk_gnt("d0", 0, 1);
        tick();
        st_req_i = 0; st_stc_i = 0; ld_req_i = 1;
        settle();
        chk("d1.st_en", 64'(dc_st_en_o), 1);
        chk("d1.stc", 64'(dc_stc_flag_o), 1);
        chk_gnt("d1", 0, 0);
        tick();
        settle(); chk_gnt("d2.wait", 0, 0);
        chk("d2.st_en", 64'(dc_st_en_o), 0);
        tick();
        Dcache_stc_success_i = 1; Dcache_stc_fail_i = 1;
        settle(); chk_gnt("d3.wait", 0, 0);
        chk("d3.done", 64'(stc_done_o), 0);
        tick();
        Dcache_stc_success_i = 0; Dcache_stc_fail_i = 0; ld_req_i = 0;
        chk("d4.done", 64'(stc_done_o), 1);
        chk("d4.result", 64'(stc_result_o), 0);
        tick();
        chk("d5.done", 64'(stc_done_o), 0);

        // STC minimum round trip with success
        st_req_i = 1; st_stc_i = 1;
        tick();
        st_req_i = 0; st_stc_i = 0;
        tick();
        Dcache_stc_success_i = 1;
        tick();
        Dcache_stc_success_i = 0;
        chk("e.done", 64'(stc_done_o), 1);
        chk("e.result", 64'(stc_result_o), 1);
        tick();

        // Reset in STC_WAIT discards the STC without a completion pulse
        st_req_i = 1; st_stc_i = 1;
        tick();
        st_req_i = 0; st_stc_i = 0;
        tick();
        rst = 1; Dcache_stc_success_i = 1;
        tick();
        rst = 0; Dcache_stc_success_i = 0;
        chk("f.done", 64'(stc_done_o), 0);
        chk("f.st_en", 64'(dc_st_en_o), 0);
        tick();

        // Store starvation under continuous load traffic
        ld_req_i = 1; st_req_i = 1; st_addr_i = 64'h700;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk_gnt($sformatf("g%0d", i), !(AGE_EN && i == 4), AGE_EN && i == 4);
            tick();
        end
        sq_full_i = 1;
        settle(); chk_gnt("g.full", 0, 1);
        tick();
        ld_req_i = 0; st_req_i = 0; sq_full_i = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ldst_port_arb.md
# ldst_port_arb

Sequencing controller and arbiter for the single data-cache request port shared by the load/store unit. Loads waiting to issue and stores retiring from the store queue (including store-conditionals) both request the port; the arbiter grants one per cycle and holds it in a one-entry issue register while the cache signals MSHR stall. It also serialises store-conditional completion and squashes a mispredicted load before the cache accepts it. It sits between the LSQ request logic and the Dcache/MSHR front end.

## Interface
Parameters:
- ST_WAIT_MAX, 4: cycles a pending store may lose arbitration before it is forced to win (only with MEM_ARB_AGE_EN).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ld_req_i  in  1  load requests port; held stable until granted
- ld_addr_i  in  64  load address
- ld_br_mask_i  in  `BR_MASK_W  branch mask of requesting load
- ld_gnt_o  out  1  load granted this cycle
- st_req_i  in  1  retiring store requests port; held until granted
- st_addr_i, st_data_i  in  64 each  store address / data
- st_stc_i  in  1  request is a store-conditional
- st_gnt_o  out  1  store granted this cycle
- sq_full_i  in  1  store queue full
- rob_br_recovery_i  in  1  mispredict squash this cycle
- rob_br_pred_correct_i  in  1  branch resolved correct
- rob_br_tag_fix_i  in  `BR_MASK_W  resolved branch tag
- Dcache_mshr_stall_i  in  1  cache cannot accept the presented request
- Dcache_stc_success_i, Dcache_stc_fail_i  in  1 each  STC outcome
- dc_ld_en_o, dc_st_en_o  out  1 each  request presented to cache
- dc_ld_addr_o, dc_st_addr_o, dc_st_data_o  out  64 each  request payload
- dc_stc_flag_o  out  1  presented store is an STC
- stc_done_o  out  1  one-cycle STC completion pulse
- stc_result_o  out  1  1 = STC succeeded (valid with stc_done_o)

## Operation
- States: IDLE (issue register empty), ISSUE (request presented), STC_WAIT (accepted STC awaiting outcome).
- Grant possible when state is IDLE, or ISSUE with Dcache_mshr_stall_i low and presented request not an STC. Never in STC_WAIT.
- Priority: load wins by default. Store wins if st_req_i and (sq_full_i or ~ld_req_i or age counter at ST_WAIT_MAX).
- No load grant in a cycle with rob_br_recovery_i high; stores are still granted.
- At most one of ld_gnt_o/st_gnt_o per cycle. Both are combinational from the current state and inputs.
- Issue register holds: type, address, data, stc flag, and br_mask (loads only).
- ISSUE transitions:
  - stall high → ISSUE, payload held unchanged;
  - accepted STC → STC_WAIT;
  - accepted and new grant → ISSUE with the new payload;
  - otherwise → IDLE.
- Squash: a held load with (br_mask & rob_br_tag_fix_i) != 0 during recovery is dropped; the state goes to IDLE regardless of stall.
- On rob_br_pred_correct_i, clear rob_br_tag_fix_i bits from the held br_mask.
- STC_WAIT → IDLE on success or fail. stc_done_o pulses the next cycle. stc_result_o = success & ~fail, so simultaneous success and fail reports failure.

## Timing
- Reset values: all outputs 0, state IDLE, age counter 0. Reset mid-ISSUE or mid-STC_WAIT discards the request with no stc_done_o.
- Latency: grant in cycle N → dc_*_en_o high from cycle N+1 until the first cycle with Dcache_mshr_stall_i low, inclusive.
- Back-to-back: requests can be accepted every cycle while stall stays low.
- dc_ld_en_o and dc_st_en_o are never both high. The payload stays stable while en is high.
- STC round trip: minimum of 3 cycles from grant to stc_done_o.

## Configuration
- MEM_ARB_AGE_EN defined: a saturating counter of width $clog2(ST_WAIT_MAX)+1.
  - Increments each cycle st_req_i is high and not granted; clears on st_gnt_o.
  - At ST_WAIT_MAX the store beats a load.
- Undefined: the counter is absent. Stores win only on sq_full_i or no load request.

## Structure
- The shared definitions package holds:
  - the state enum (ARB_IDLE, ARB_ISSUE, ARB_STC_WAIT);
  - the issue-entry struct (is_st, addr, data, stc, br_mask);
  - `BR_MASK_W.
- One sub-module, ldst_arb_age_ctr, for the counter, instantiated only under MEM_ARB_AGE_EN.

## Test plan
- Load 0x100 and store 0x200 both requested from IDLE, sq_full_i=0:
  - ld_gnt_o in cycle 0; dc_ld_en_o with addr 0x100 in cycle 1;
  - st_gnt_o in cycle 1; dc_st_en_o in cycle 2.
- Load presented with stall high for 3 cycles → dc_ld_en_o held 4 cycles with unchanged addr; no grants during the stall.
- Held load with br_mask 0b0010, recovery with tag_fix 0b0010 while stalled → dc_ld_en_o low the next cycle, state IDLE.
- STC granted, accepted, success and fail both high after 2 cycles → stc_done_o=1, stc_result_o=0; no grant throughout STC_WAIT.
- With MEM_ARB_AGE_EN and ST_WAIT_MAX=4, continuous ld_req_i and st_req_i → store granted on its 5th requesting cycle. Without the macro, store granted only when sq_full_i is raised.
